// File: rtl/issue_select_scheduler_if.sv
// Issue-select handshake bundle: RS readiness in, issue slots and grants out.
interface issue_select_scheduler_if #(
    parameter int N_WAY = 3,
    parameter int N_RS  = 16
);
    localparam int IW = $clog2(N_RS);
    localparam int CW = $clog2(N_WAY) + 1;

    logic [N_RS-1:0]            rs_ready;
    logic [N_RS-1:0]            rs_is_mul;
    logic                       ex_stall;
    logic                       squash;
    logic [N_WAY-1:0]           slot_valid;
    logic [N_WAY-1:0][IW-1:0]   slot_idx;
    logic [N_RS-1:0]            rs_grant;
    logic [CW-1:0]              issue_count;
    logic [CW-1:0]              alu_budget;

    // Pipeline side: drives readiness/control, receives grants.
    modport master (
        output rs_ready, rs_is_mul, ex_stall, squash,
        input  slot_valid, slot_idx, rs_grant, issue_count, alu_budget
    );

    // Scheduler side.
    modport slave (
        input  rs_ready, rs_is_mul, ex_stall, squash,
        output slot_valid, slot_idx, rs_grant, issue_count, alu_budget
    );
endinterface

// File: rtl/issue_select_scheduler.sv
// Round-robin issue select with shared-multiplier limit and CDB writeback
// reservation. Grants are combinational from the current ready vector;
// the scan pointer and the writeback reservation table are registered.
module issue_select_scheduler #(
    parameter int N_WAY   = 3,
    parameter int N_RS    = 16,
    parameter int MUL_LAT = 4,
    parameter int N_MUL   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    issue_select_scheduler_if.slave io_bus
);
    localparam int IW = $clog2(N_RS);
    localparam int CW = $clog2(N_WAY) + 1;
    localparam int PW = IW + 1;
    localparam logic [CW-1:0] C_NWAY = CW'(N_WAY);
    localparam logic [CW-1:0] C_NMUL = CW'(N_MUL);
    localparam logic [PW-1:0] C_NRS  = PW'(N_RS);

    // r_resv[k] counts writebacks already committed for cycle now+k.
    // r_resv[MUL_LAT] is always zero before issue, so muls need no CDB check.
    logic [IW-1:0]            r_rr_ptr;
    logic [CW-1:0]            r_resv [1:MUL_LAT];

    logic                     w_active;
    logic [CW-1:0]            w_alu_budget;
    logic [CW-1:0]            w_total;
    logic [CW-1:0]            w_mul_cnt;
    logic [CW-1:0]            w_alu_cnt;
    logic [PW-1:0]            w_pos;
    logic [IW-1:0]            w_idx;
    logic                     w_take;
    logic [IW-1:0]            w_last;
    logic                     w_any;
    logic [N_RS-1:0]          w_grant;
    logic [N_WAY-1:0]         w_slot_valid;
    logic [N_WAY-1:0][IW-1:0] w_slot_idx;
    logic [PW-1:0]            w_next_sum;
    logic [IW-1:0]            w_next_ptr;

    // Reset is folded in so that outputs drop immediately while it is low.
    assign w_active     = i_rst_n & ~io_bus.squash & ~io_bus.ex_stall;
    assign w_alu_budget = C_NWAY - r_resv[1];

    // Rotating scan from r_rr_ptr; ineligible entries are skipped, not blocking.
    always_comb begin
        w_grant      = '0;
        w_slot_valid = '0;
        w_slot_idx   = '0;
        w_total      = '0;
        w_mul_cnt    = '0;
        w_alu_cnt    = '0;
        w_last       = '0;
        w_any        = 1'b0;
        w_pos        = '0;
        w_idx        = '0;
        w_take       = 1'b0;
        for (int i = 0; i < N_RS; i++) begin
            w_pos = {1'b0, r_rr_ptr} + PW'(i);
            if (w_pos >= C_NRS) begin
                w_pos = w_pos - C_NRS;
            end
            w_idx  = w_pos[IW-1:0];
            w_take = 1'b0;
            if (w_active && io_bus.rs_ready[w_idx] && (w_total < C_NWAY)) begin
                if (io_bus.rs_is_mul[w_idx]) begin
                    w_take = (w_mul_cnt < C_NMUL);
                end else begin
                    w_take = (w_alu_cnt < w_alu_budget);
                end
            end
            if (w_take) begin
                for (int s = 0; s < N_WAY; s++) begin
                    if (w_total == CW'(s)) begin
                        w_slot_valid[s] = 1'b1;
                        w_slot_idx[s]   = w_idx;
                    end
                end
                w_grant[w_idx] = 1'b1;
                if (io_bus.rs_is_mul[w_idx]) begin
                    w_mul_cnt = w_mul_cnt + CW'(1);
                end else begin
                    w_alu_cnt = w_alu_cnt + CW'(1);
                end
                w_total = w_total + CW'(1);
                w_last  = w_idx;
                w_any   = 1'b1;
            end
        end
    end

    // Pointer resumes just past the last granted entry, wrapping at N_RS.
    always_comb begin
        w_next_sum = {1'b0, w_last} + PW'(1);
        w_next_ptr = (w_next_sum >= C_NRS) ? '0 : w_next_sum[IW-1:0];
    end

    // State update: squash kills in-flight muls, stall freezes everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
            for (int k = 1; k <= MUL_LAT; k++) begin
                r_resv[k] <= '0;
            end
        end else if (io_bus.squash) begin
            r_rr_ptr <= '0;
            for (int k = 1; k <= MUL_LAT; k++) begin
                r_resv[k] <= '0;
            end
        end else if (!io_bus.ex_stall) begin
            if (w_any) begin
                r_rr_ptr <= w_next_ptr;
            end
            for (int k = 1; k < MUL_LAT; k++) begin
                if (k == MUL_LAT - 1) begin
                    r_resv[k] <= r_resv[k+1] + w_mul_cnt;
                end else begin
                    r_resv[k] <= r_resv[k+1];
                end
            end
            r_resv[MUL_LAT] <= '0;
        end
    end

    assign io_bus.slot_valid  = w_slot_valid;
    assign io_bus.slot_idx    = w_slot_idx;
    assign io_bus.rs_grant    = w_grant;
    assign io_bus.issue_count = w_total;
    assign io_bus.alu_budget  = w_alu_budget;
endmodule
